// File: rtl/m_axi_cnt_pkg.sv
// Shared types and AXI constants for the burst counter writer.
// State encoding, burst/response codes and the awsize helper.
package m_axi_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Legal widths are 32/64/128; anything else falls back to a 4-byte beat.
  function automatic logic [2:0] axi_size(input int data_width);
    case (data_width)
      64:      return 3'd3;
      128:     return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/m_axi_cnt_beat_ctr.sv
// Beat index within a burst, last-beat flag and the free-running data counter.
// Zero latency to outputs; advances only on a W handshake, so data/last hold under stall.
module m_axi_cnt_beat_ctr #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  burst_start,
  input  logic [7:0]            len,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic                  beat_hs,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  logic [7:0]            beat_q;
  logic [DATA_WIDTH-1:0] data_q;

  // The data counter is only cleared by reset so the sequence continues across runs.
  always_ff @(posedge clk) begin
    if (areset) begin
      beat_q <= '0;
      data_q <= '0;
    end else begin
      if (burst_start) begin
        beat_q <= '0;
      end else if (beat_hs) begin
        beat_q <= beat_q + 8'd1;
      end
      if (beat_hs) begin
        data_q <= data_q + step;
      end
    end
  end

  assign data = data_q;
  assign last = (beat_q == len);

endmodule

// File: rtl/m_axi_cnt_burst.sv
// AXI4 write master streaming an incrementing counter as INCR bursts, one burst in flight.
// AW then W then B per burst; every channel waits on its ready/valid, bursts are never truncated.
module m_axi_cnt_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    cfg_enable_i,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr_i,
  input  logic [7:0]              cfg_burst_len_i,
  input  logic [15:0]             cfg_num_bursts_i,
  input  logic [DATA_WIDTH-1:0]   cfg_incr_step_i,
  input  logic                    cfg_stop_on_err_i,
  output logic [ID_WIDTH-1:0]     awid_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [7:0]              awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_WIDTH-1:0]     bid_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [15:0]             bursts_done_o
);

  import m_axi_cnt_pkg::*;

  localparam int                    BYTES      = DATA_WIDTH / 8;
  localparam logic [2:0]            AWSIZE     = axi_size(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  typedef struct packed {
    logic [7:0]            len;
    logic [15:0]           num;
    logic [DATA_WIDTH-1:0] step;
    logic                  stop_on_err;
  } run_cfg_t;

  state_e                state_q, state_d;
  run_cfg_t              cfg_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic [15:0]           bursts_q;
  logic [15:0]           bursts_inc;
  logic                  err_q, busy_q, done_q;
  logic                  start, aw_hs, w_hs, b_hs, b_err;
  logic                  count_reached, run_end, beat_last;
  logic                  unused_bid;

  assign unused_bid    = ^bid_i;

  assign start         = (state_q == ST_IDLE) && cfg_enable_i;
  assign aw_hs         = awvalid_o && awready_i;
  assign w_hs          = wvalid_o && wready_i;
  assign b_hs          = bready_o && bvalid_i;
  assign b_err         = (bresp_i != AXI_RESP_OKAY);
  assign bursts_inc    = bursts_q + 16'd1;
  assign count_reached = (cfg_q.num != 16'd0) && (bursts_inc == cfg_q.num);
  // A dropped enable or an error stop only ends the run once the B handshake is done.
  assign run_end       = (cfg_q.stop_on_err && (err_q || b_err)) || !cfg_enable_i || count_reached;
  assign burst_bytes   = (ADDR_WIDTH'(cfg_q.len) + ADDR_WIDTH'(1)) << AWSIZE;

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_enable_i) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        awvalid_o = 1'b1;
        if (awready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        wvalid_o = 1'b1;
        if (wready_i && beat_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_d = run_end ? ST_IDLE : ST_ADDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      cfg_q    <= '0;
      addr_q   <= '0;
      bursts_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        cfg_q.len         <= cfg_burst_len_i;
        cfg_q.num         <= cfg_num_bursts_i;
        cfg_q.step        <= cfg_incr_step_i;
        cfg_q.stop_on_err <= cfg_stop_on_err_i;
        addr_q            <= cfg_base_addr_i & ALIGN_MASK;
        bursts_q          <= '0;
        err_q             <= 1'b0;
        busy_q            <= 1'b1;
      end
      if (b_hs) begin
        bursts_q <= bursts_inc;
        addr_q   <= addr_q + burst_bytes;
        if (b_err) err_q <= 1'b1;
        if (run_end) begin
          busy_q <= 1'b0;
          done_q <= count_reached;
        end
      end
    end
  end

  m_axi_cnt_beat_ctr #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_beat_ctr (
    .clk         (clk),
    .areset      (areset),
    .burst_start (aw_hs),
    .len         (cfg_q.len),
    .step        (cfg_q.step),
    .beat_hs     (w_hs),
    .data        (wdata_o),
    .last        (beat_last)
  );

  assign awid_o        = ID_WIDTH'(AXI_ID);
  assign awaddr_o      = addr_q;
  assign awlen_o       = cfg_q.len;
  assign awsize_o      = AWSIZE;
  assign awburst_o     = AXI_BURST_INCR;
  assign wstrb_o       = '1;
  assign wlast_o       = wvalid_o && beat_last;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign bursts_done_o = bursts_q;

endmodule

// File: tb/tb_m_axi_cnt_burst.sv
// Directed bench: behavioural run/burst model checked every cycle plus literal per-test expectations.
module tb_m_axi_cnt_burst;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cfg_enable_i = 1'b0;
  logic [63:0] cfg_base_addr_i = '0;
  logic [7:0]  cfg_burst_len_i = '0;
  logic [15:0] cfg_num_bursts_i = '0;
  logic [31:0] cfg_incr_step_i = '0;
  logic        cfg_stop_on_err_i = 1'b0;
  logic [3:0]  awid_o;
  logic [63:0] awaddr_o;
  logic [7:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o, wvalid_o, wready_i;
  logic [3:0]  bid_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;
  logic        busy_o, done_o, err_o;
  logic [15:0] bursts_done_o;

  m_axi_cnt_burst dut (
    .clk(clk), .areset(areset), .cfg_enable_i(cfg_enable_i),
    .cfg_base_addr_i(cfg_base_addr_i), .cfg_burst_len_i(cfg_burst_len_i),
    .cfg_num_bursts_i(cfg_num_bursts_i), .cfg_incr_step_i(cfg_incr_step_i),
    .cfg_stop_on_err_i(cfg_stop_on_err_i),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
    .bready_o(bready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .bursts_done_o(bursts_done_o)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mon_on = 1'b0;
  bit          m_busy, m_done, m_err, m_stop;
  logic [15:0] m_bursts, m_num;
  logic [31:0] m_cnt, m_step;
  logic [7:0]  m_len, m_beat;
  logic [63:0] m_addr;
  bit          p_aw_stall, p_w_stall;
  logic [31:0] cap_w[$];
  logic [63:0] cap_aw[$];

  always @(negedge clk) begin
    if (mon_on) begin
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("err", err_o, m_err);
      chk("bursts_done", bursts_done_o, m_bursts);
      if (p_aw_stall) chk("aw_hold", awvalid_o, 1'b1);
      if (p_w_stall)  chk("w_hold", wvalid_o, 1'b1);
      if (awvalid_o) begin
        chk("awaddr", awaddr_o, m_addr);
        chk("awlen", awlen_o, m_len);
        chk("awsize", awsize_o, 3'd2);
        chk("awburst", awburst_o, 2'b01);
        chk("awid", awid_o, 4'd0);
      end
      if (wvalid_o) begin
        chk("wdata", wdata_o, m_cnt);
        chk("wlast", wlast_o, (m_beat == m_len));
        chk("wstrb", wstrb_o, 4'hF);
      end
    end
    m_done     = 1'b0;
    p_aw_stall = awvalid_o && !awready_i;
    p_w_stall  = wvalid_o && !wready_i;
    if (areset) begin
      m_busy = 0; m_err = 0; m_bursts = '0; m_cnt = '0; m_beat = '0;
      p_aw_stall = 0; p_w_stall = 0;
    end else begin
      if (!m_busy && cfg_enable_i) begin
        m_busy = 1; m_err = 0; m_bursts = '0;
        m_len = cfg_burst_len_i; m_num = cfg_num_bursts_i;
        m_step = cfg_incr_step_i; m_stop = cfg_stop_on_err_i;
        m_addr = cfg_base_addr_i & ~64'h3;
      end
      if (awvalid_o && awready_i) begin
        cap_aw.push_back(awaddr_o);
        m_beat = '0;
      end
      if (wvalid_o && wready_i) begin
        cap_w.push_back(wdata_o);
        m_cnt = m_cnt + m_step;
        m_beat = m_beat + 8'd1;
      end
      if (bvalid_i && bready_o) begin
        m_bursts = m_bursts + 16'd1;
        m_addr = m_addr + (64'(m_len) + 64'd1) * 64'd4;
        if (bresp_i != 2'b00) m_err = 1;
        if ((m_stop && m_err) || !cfg_enable_i || (m_num != 0 && m_bursts == m_num)) begin
          m_busy = 0;
          m_done = (m_num != 0 && m_bursts == m_num);
        end
      end
    end
  end

  // ---------------- slave-side drivers ----------------
  int aw_delay = 0;
  bit w_toggle = 0;
  int aw_wait = 0;
  int b_idx = 0;
  int err_idx = -1;

  initial begin
    awready_i = 0; wready_i = 0;
    forever begin
      @(posedge clk); #1;
      if (awvalid_o) aw_wait++; else aw_wait = 0;
      awready_i = (aw_wait > aw_delay);
      wready_i  = w_toggle ? !wready_i : 1'b1;
    end
  end

  initial begin
    bvalid_i = 0; bresp_i = 2'b00; bid_i = 4'd0;
    forever begin
      @(posedge clk); #1;
      if (bvalid_i) begin
        bvalid_i = 0;
        b_idx++;
      end else if (bready_o) begin
        bvalid_i = 1;
        bresp_i  = (b_idx == err_idx) ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- sequencing tasks ----------------
  task automatic do_reset();
    cfg_enable_i = 0;
    areset = 1;
    repeat (2) @(posedge clk);
    #1;
    areset = 0;
    cap_w.delete();
    cap_aw.delete();
    b_idx = 0;
  endtask

  task automatic start_run(input logic [63:0] base, input logic [7:0] len, input logic [15:0] num,
                           input logic [31:0] step, input bit stop, input int eidx);
    cfg_base_addr_i = base; cfg_burst_len_i = len; cfg_num_bursts_i = num;
    cfg_incr_step_i = step; cfg_stop_on_err_i = stop;
    err_idx = eidx; b_idx = 0;
    cfg_enable_i = 1;
  endtask

  task automatic wait_end(output bit saw_done);
    bit started = 0;
    int n = 0;
    saw_done = 0;
    while (n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (done_o) saw_done = 1;
      if (busy_o) started = 1;
      else if (started) break;
    end
    if (n >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: run still busy after %0d cycles", n);
    end
    cfg_enable_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_cond_timeout(input string name);
    n_vec++; n_err++;
    $display("FAIL %s: condition not reached within cycle budget", name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit d;
    int n;
    do_reset();
    mon_on = 1;
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_bready", bready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_bursts", bursts_done_o, 0);

    // single 4-beat burst
    start_run(64'h1000, 8'd3, 16'd1, 32'd1, 0, -1);
    wait_end(d);
    chk("t1_done", d, 1);
    chk("t1_aw_n", cap_aw.size(), 1);
    chk("t1_aw0", cap_aw[0], 64'h1000);
    chk("t1_w_n", cap_w.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_wdata", cap_w[i], i);
    chk("t1_bursts", bursts_done_o, 1);

    // three 2-beat bursts, step 5
    do_reset();
    start_run(64'h2000, 8'd1, 16'd3, 32'd5, 0, -1);
    wait_end(d);
    chk("t2_done", d, 1);
    chk("t2_aw0", cap_aw[0], 64'h2000);
    chk("t2_aw1", cap_aw[1], 64'h2008);
    chk("t2_aw2", cap_aw[2], 64'h2010);
    chk("t2_w_n", cap_w.size(), 6);
    for (int i = 0; i < 6; i++) chk("t2_wdata", cap_w[i], i * 5);

    // backpressure, unaligned base
    do_reset();
    aw_delay = 4; w_toggle = 1;
    start_run(64'h3001, 8'd3, 16'd2, 32'd2, 0, -1);
    wait_end(d);
    aw_delay = 0; w_toggle = 0;
    chk("t3_done", d, 1);
    chk("t3_aw0", cap_aw[0], 64'h3000);
    chk("t3_aw1", cap_aw[1], 64'h3010);
    chk("t3_w_n", cap_w.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_wdata", cap_w[i], i * 2);

    // SLVERR on 2nd of 4 bursts, stop on error
    do_reset();
    start_run(64'h4000, 8'd1, 16'd4, 32'd1, 1, 1);
    wait_end(d);
    chk("t4a_done", d, 0);
    chk("t4a_err", err_o, 1);
    chk("t4a_bursts", bursts_done_o, 2);
    chk("t4a_w_n", cap_w.size(), 4);
    // same without stop; counter continues from the previous run
    cap_w.delete(); cap_aw.delete();
    start_run(64'h4000, 8'd1, 16'd4, 32'd1, 0, 1);
    wait_end(d);
    chk("t4b_done", d, 1);
    chk("t4b_err", err_o, 1);
    chk("t4b_bursts", bursts_done_o, 4);
    chk("t4b_w0", cap_w[0], 32'd4);
    chk("t4b_w_n", cap_w.size(), 8);

    // counter wrap, then continuous run stopped by dropping enable mid-burst
    do_reset();
    start_run(64'h5000, 8'd0, 16'd1, 32'hFFFF_FFFF, 0, -1);
    wait_end(d);
    chk("t5a_w0", cap_w[0], 32'd0);
    cap_w.delete(); cap_aw.delete();
    start_run(64'h5000, 8'd2, 16'd0, 32'd1, 0, -1);
    n = 0;
    while (!(bursts_done_o == 16'd1 && wvalid_o) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) wait_cond_timeout("t5_second_burst");
    cfg_enable_i = 0;
    wait_end(d);
    chk("t5_done", d, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_bursts", bursts_done_o, 2);
    chk("t5_w_n", cap_w.size(), 6);
    chk("t5_w0", cap_w[0], 32'hFFFF_FFFF);
    for (int i = 1; i < 6; i++) chk("t5_wdata", cap_w[i], i - 1);
    chk("t5_aw1", cap_aw[1], 64'h500C);

    // reset in the middle of a burst
    do_reset();
    start_run(64'h6000, 8'd7, 16'd1, 32'd3, 0, -1);
    n = 0;
    while (cap_w.size() < 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) wait_cond_timeout("t6_beats");
    areset = 1; cfg_enable_i = 0;
    @(posedge clk); #1;
    areset = 0;
    chk("t6_awvalid", awvalid_o, 0);
    chk("t6_wvalid", wvalid_o, 0);
    chk("t6_bready", bready_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_bursts", bursts_done_o, 0);
    cap_w.delete(); cap_aw.delete();
    start_run(64'h6000, 8'd0, 16'd1, 32'd1, 0, -1);
    wait_end(d);
    chk("t6_done", d, 1);
    chk("t6_w_n", cap_w.size(), 1);
    chk("t6_w0", cap_w[0], 32'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
